// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-way bus arbiter.
package bus_arb_pkg;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = $clog2(MAX_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // First set bit searching upward from last_id+1, wrapping at num_req.
  function automatic int rr_select(input logic [MAX_REQ-1:0] bids,
                                   input int                 last_id,
                                   input int                 num_req);
    int                  win;
    int                  idx;
    logic [MAX_ID_W-1:0] pos;
    win = 0;
    // Walk farthest to nearest so the nearest hit is the one that sticks.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = (last_id + k) % num_req;
        pos = MAX_ID_W'(idx);
        if (bids[pos]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational priority rotator: picks a winner from an eligible mask,
// searching upward from last_id+1 or, when REVERSE, downward from last_id.
module arb_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter bit REVERSE = 1'b0,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  logic [MAX_REQ-1:0]  elig_ext;
  logic [MAX_ID_W-1:0] pos;
  int                  win_int;
  int                  idx;
  int                  last_int;

  always_comb begin
    elig_ext              = '0;
    elig_ext[NUM_REQ-1:0] = elig;
    last_int              = int'(last_id);
    pos                   = '0;
    idx                   = 0;
    win_int               = 0;
    found                 = |elig;
    if (!REVERSE) begin
      win_int = rr_select(elig_ext, last_int, NUM_REQ);
    end else begin
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
        if (k < NUM_REQ) begin
          idx = (last_int - k + NUM_REQ) % NUM_REQ;
          pos = MAX_ID_W'(idx);
          if (elig_ext[pos]) win_int = idx;
        end
      end
    end
    winner = ID_W'(win_int);
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-way bus arbiter with round-robin or fixed-priority selection and a
// bounded hold time that forces hand-over under contention.
//
//   state | meaning
//   IDLE  | no grant; arbitrate eligible bids this cycle (bus turnaround)
//   BUSY  | one owner holds the bus; watch for release or hold expiry
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] bus_bid,
  output logic [NUM_REQ-1:0] bus_grant,
  output logic               bus_busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               preempt
);

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  arb_state_e         state, state_nxt;
  logic [HC_W-1:0]    hold_cnt, hold_nxt;
  logic [ID_W-1:0]    last_id, last_nxt;
  logic               mask_vld, mask_vld_nxt;
  logic [ID_W-1:0]    mask_id, mask_id_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               preempt_nxt;

  logic [NUM_REQ-1:0] mask_vec;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    pick_last;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic               owner_bid;
  logic               others_bid;
  logic               hold_expire;

  assign mask_vec    = mask_vld ? (NUM_REQ'(1) << mask_id) : '0;
  assign elig        = bus_bid & ~mask_vec;
  // Fixed priority reuses the rotator anchored at the top index.
  assign pick_last   = (RR_MODE != 0) ? last_id : LAST_INIT;
  assign owner_bid   = |(bus_bid & bus_grant);
  assign others_bid  = |(bus_bid & ~bus_grant);
  assign hold_expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others_bid;

  arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .REVERSE (RR_MODE == 0),
    .ID_W    (ID_W)
  ) u_picker (
    .elig    (elig),
    .last_id (pick_last),
    .winner  (winner),
    .found   (found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_grant <= '0;
      bus_busy  <= 1'b0;
      grant_id  <= '0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= LAST_INIT;
      mask_vld  <= 1'b0;
      mask_id   <= '0;
    end else begin
      state     <= state_nxt;
      bus_grant <= grant_nxt;
      bus_busy  <= |grant_nxt;
      grant_id  <= id_nxt;
      preempt   <= preempt_nxt;
      hold_cnt  <= hold_nxt;
      last_id   <= last_nxt;
      mask_vld  <= mask_vld_nxt;
      mask_id   <= mask_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = BUSY;
      BUSY: if (!owner_bid || hold_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt    = '0;
    id_nxt       = '0;
    preempt_nxt  = 1'b0;
    hold_nxt     = '0;
    last_nxt     = last_id;
    mask_vld_nxt = mask_vld;
    mask_id_nxt  = mask_id;
    case (state)
      IDLE: begin
        // The exclusion lasts for exactly one arbitration, granted or not.
        mask_vld_nxt = 1'b0;
        if (found) begin
          grant_nxt = NUM_REQ'(1) << winner;
          id_nxt    = winner;
          last_nxt  = winner;
        end
      end
      BUSY: begin
        if (state_nxt == BUSY) begin
          grant_nxt = bus_grant;
          id_nxt    = grant_id;
          hold_nxt  = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end else if (owner_bid) begin
          preempt_nxt  = 1'b1;
          mask_vld_nxt = 1'b1;
          mask_id_nxt  = grant_id;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: A = 4-way round-robin, B = 2-way fixed priority,
// both with MAX_HOLD=4, checked against a queue-fed reference model.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] bid_a = '0, grant_a;
  logic       busy_a, pre_a;
  logic [1:0] id_a;
  logic [1:0] bid_b = '0, grant_b;
  logic       busy_b, pre_b;
  logic       id_b;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .bus_bid(bid_a), .bus_grant(grant_a),
    .bus_busy(busy_a), .grant_id(id_a), .preempt(pre_a));

  bus_arbiter_rr #(.NUM_REQ(2), .RR_MODE(0), .MAX_HOLD(4)) dut_b (
    .clk(clk), .reset(reset), .bus_bid(bid_b), .bus_grant(grant_b),
    .bus_busy(busy_b), .grant_id(id_b), .preempt(pre_b));

  typedef struct {
    int grant;
    int busy;
    int id;
    int preempt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_pass = 0;
  int   n_total = 0;

  int   m_owner[2], m_held[2], m_last[2], m_mask[2];
  int   obs_pre_a = 0, obs_pre_b = 0;
  int   wait_a[4];
  bit   prev_g_a[4];
  int   max_wait_a = 0;
  bit   bid_r[2][4];
  int   tx_len[2][4];

  function automatic int nreq(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    n_total++;
    if (act <= lim) n_pass++;
    else $display("FAIL %s: got %0d, limit %0d", name, act, lim);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_last[k]  = nreq(k) - 1;
      m_mask[k]  = -1;
    end
    for (int c = 0; c < 4; c++) begin
      wait_a[c]   = 0;
      prev_g_a[c] = 1'b0;
    end
  endtask

  // Reference: owner index (-1 idle), grant cycles held, rotation pointer,
  // and a one-shot exclusion for a requester just forced off the bus.
  task automatic model_step(input int k, input logic [3:0] bids, output exp_t e);
    int n, w, c;
    bit others;
    n = nreq(k);
    e.preempt = 0;
    if (m_owner[k] < 0) begin
      w = -1;
      if (k == 0) begin
        for (int j = 1; j <= n; j++) begin
          c = (m_last[k] + j) % n;
          if (w < 0 && bids[c] && c != m_mask[k]) w = c;
        end
      end else begin
        for (int i = n - 1; i >= 0; i--)
          if (w < 0 && bids[i] && i != m_mask[k]) w = i;
      end
      m_mask[k] = -1;
      if (w >= 0) begin
        m_owner[k] = w;
        m_last[k]  = w;
        m_held[k]  = 1;
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < n; i++)
        if (i != m_owner[k] && bids[i]) others = 1'b1;
      if (!bids[m_owner[k]]) begin
        m_owner[k] = -1;
      end else if (others && m_held[k] >= 4) begin
        e.preempt  = 1;
        m_mask[k]  = m_owner[k];
        m_owner[k] = -1;
      end else begin
        m_held[k]++;
      end
    end
    e.grant = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
    e.busy  = (m_owner[k] >= 0) ? 1 : 0;
    e.id    = (m_owner[k] >= 0) ? m_owner[k] : 0;
  endtask

  // Transactions: raise with pct chance, release after tx_len granted cycles.
  task automatic gen(input int k, input int pct, input int fixed_len, output logic [3:0] b);
    b = '0;
    for (int c = 0; c < nreq(k); c++) begin
      if (!bid_r[k][c]) begin
        if (int'($urandom_range(99)) < pct) begin
          bid_r[k][c]  = 1'b1;
          tx_len[k][c] = (fixed_len > 0) ? fixed_len : int'($urandom_range(8, 1));
        end
      end else if (m_owner[k] == c) begin
        tx_len[k][c]--;
        if (tx_len[k][c] <= 0) bid_r[k][c] = 1'b0;
      end else if (pct < 100 && $urandom_range(63) == 0) begin
        bid_r[k][c] = 1'b0;
      end
      b[c] = bid_r[k][c];
    end
  endtask

  // Cycles a bidding requester sits ungranted, not counting the cycle right
  // after it lost the bus.
  task automatic track_wait();
    for (int c = 0; c < 4; c++) begin
      if (grant_a[c]) begin
        wait_a[c]   = 0;
        prev_g_a[c] = 1'b1;
      end else begin
        if (!bid_a[c]) wait_a[c] = 0;
        else if (!prev_g_a[c]) wait_a[c]++;
        prev_g_a[c] = 1'b0;
        if (wait_a[c] > max_wait_a) max_wait_a = wait_a[c];
      end
    end
  endtask

  task automatic cycle(input logic [3:0] ba, input logic [1:0] bb, input bit skip_neg = 1'b0);
    exp_t e;
    if (!skip_neg) begin
      @(negedge clk);
      track_wait();
    end
    bid_a = ba;
    bid_b = bb;
    @(posedge clk);
    model_step(0, ba, e);
    q_a.push_back(e);
    model_step(1, {2'b00, bb}, e);
    q_b.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (pre_a) obs_pre_a++;
      if (pre_b) obs_pre_b++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("A.grant", int'(grant_a), e.grant);
        chk("A.busy", int'(busy_a), e.busy);
        chk("A.id", int'(id_a), e.id);
        chk("A.preempt", int'(pre_a), e.preempt);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("B.grant", int'(grant_b), e.grant);
        chk("B.busy", int'(busy_b), e.busy);
        chk("B.id", int'(id_b), e.id);
        chk("B.preempt", int'(pre_b), e.preempt);
      end
    end
  end

  initial begin : stim
    logic [3:0] ba, bb;
    int p0;
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        bid_r[k][c]  = 1'b0;
        tx_len[k][c] = 0;
      end
    #1 reset = 1'b0;
    #1;
    chk("rst.A.grant", int'(grant_a), 0);
    chk("rst.A.busy", int'(busy_a), 0);
    chk("rst.A.id", int'(id_a), 0);
    chk("rst.A.preempt", int'(pre_a), 0);
    chk("rst.B.grant", int'(grant_b), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cycle(4'b0000, 2'b00, 1'b1);

    // Fixed priority: both bid, top wins; after release a turnaround then 0.
    repeat (3) cycle(4'b0000, 2'b11);
    repeat (3) cycle(4'b0000, 2'b01);
    repeat (2) cycle(4'b0000, 2'b00);

    // Hold limit: requester 1 continuous, requester 0 joins two cycles later.
    p0 = obs_pre_b;
    repeat (2) cycle(4'b0000, 2'b10);
    repeat (6) cycle(4'b0000, 2'b11);
    repeat (6) cycle(4'b0000, 2'b10);
    repeat (2) cycle(4'b0000, 2'b00);
    @(negedge clk);
    #1 chk("B.preempt_pulses", obs_pre_b - p0, 1);

    // Uncontended owner keeps the bus.
    p0 = obs_pre_a;
    repeat (50) cycle(4'b0010, 2'b00);
    repeat (2) cycle(4'b0000, 2'b00);
    @(negedge clk);
    #1 chk("A.solo_preempts", obs_pre_a - p0, 0);

    // Rotation with every requester bidding, 3-cycle transactions.
    repeat (40) begin
      gen(0, 100, 3, ba);
      cycle(ba, 2'b00);
    end
    repeat (2) cycle(4'b0000, 2'b00);

    // Asynchronous reset in the middle of a grant.
    repeat (3) cycle(4'b0100, 2'b00);
    #2 reset = 1'b0;
    #1;
    chk("arst.A.grant", int'(grant_a), 0);
    chk("arst.A.busy", int'(busy_a), 0);
    chk("arst.A.id", int'(id_a), 0);
    q_a.delete();
    q_b.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(4'b0100, 2'b00, 1'b1);
    repeat (2) cycle(4'b0100, 2'b00);
    repeat (2) cycle(4'b0000, 2'b00);

    // Random traffic on both arbiters.
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) bid_r[k][c] = 1'b0;
    repeat (3000) begin
      gen(0, 30, 0, ba);
      gen(1, 30, 0, bb);
      cycle(ba, bb[1:0]);
    end
    repeat (4) cycle(4'b0000, 2'b00);
    @(negedge clk);
    #1;
    chk_le("A.max_wait", max_wait_a, 3 * (4 + 1));
    chk("A.queue_drained", q_a.size(), 0);
    chk("B.queue_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
